// File: rtl/even_odd_tally.sv
// even_odd_tally: frames a stream of flagged samples into groups of FRAME_LEN
// and reports per-class counts/sums plus a count of inconsistent flags.
//
// state  | meaning
// ACCUM  | accepting samples, totals accumulate
// REPORT | frame complete, result held until out_ready
module even_odd_tally #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8,
  parameter int SUM_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] num,
  input  logic              even,
  input  logic              odd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt,
  output logic [SUM_W-1:0]  even_sum,
  output logic [SUM_W-1:0]  odd_sum,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0]   odd_cnt_q, odd_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]   even_sum_q, even_sum_d;
  logic [SUM_W-1:0]   odd_sum_q, odd_sum_d;
  logic               accept;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == REPORT);
  assign accept    = in_valid && in_ready;

  // Next-state: classify accepted samples, close the frame, clear on hand-off.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    even_cnt_d = even_cnt_q;
    odd_cnt_d  = odd_cnt_q;
    err_cnt_d  = err_cnt_q;
    even_sum_d = even_sum_q;
    odd_sum_d  = odd_sum_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (even && !odd) begin
            even_cnt_d = even_cnt_q + CNT_W'(1);
            even_sum_d = even_sum_q + SUM_W'(num);
          end else if (odd && !even) begin
            odd_cnt_d = odd_cnt_q + CNT_W'(1);
            odd_sum_d = odd_sum_q + SUM_W'(num);
          end else begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          // The index is left at LAST_IDX; it is cleared when the result is taken.
          if (idx_q == LAST_IDX) begin
            state_d = REPORT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_d    = ACCUM;
          idx_d      = '0;
          even_cnt_d = '0;
          odd_cnt_d  = '0;
          err_cnt_d  = '0;
          even_sum_d = '0;
          odd_sum_d  = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and totals registers; reset discards any partial or pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      idx_q      <= '0;
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
      err_cnt_q  <= '0;
      even_sum_q <= '0;
      odd_sum_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      even_cnt_q <= even_cnt_d;
      odd_cnt_q  <= odd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      even_sum_q <= even_sum_d;
      odd_sum_q  <= odd_sum_d;
    end
  end

  assign even_cnt = even_cnt_q;
  assign odd_cnt  = odd_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign even_sum = even_sum_q;
  assign odd_sum  = odd_sum_q;

endmodule

// File: tb/tb_even_odd_tally.sv
// Directed bench for even_odd_tally with FRAME_LEN=8.
module tb_even_odd_tally;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  num;
  logic        even;
  logic        odd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  even_cnt;
  logic [7:0]  odd_cnt;
  logic [15:0] even_sum;
  logic [15:0] odd_sum;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  even_odd_tally dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .even      (even),
    .odd       (odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .even_cnt  (even_cnt),
    .odd_cnt   (odd_cnt),
    .even_sum  (even_sum),
    .odd_sum   (odd_sum),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] frame1 [8] = '{8'd0, 8'd1, 8'd6, 8'd7, 8'd2, 8'd3, 8'd4, 8'd5};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; num = '0; even = 1'b0; odd = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Offer one sample and clock it in; in_valid is left asserted.
  task automatic send(input logic [7:0] n, input logic e, input logic o);
    in_valid = 1'b1; num = n; even = e; odd = o;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; num = 8'd3; even = 1'b0; odd = 1'b1; out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    checks++;
    if ({even_cnt, odd_cnt, err_cnt, even_sum, odd_sum} !== '0) begin
      errors++; $display("FAIL reset_totals got %0d/%0d/%0d/%0d/%0d exp all 0",
                         even_cnt, odd_cnt, err_cnt, even_sum, odd_sum);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL t1_pre_%0d out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
      end
      send(frame1[i], ~frame1[i][0], frame1[i][0]);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL t1_report out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready);
    end
    checks++;
    if (even_cnt !== 8'd4 || odd_cnt !== 8'd4 || even_sum !== 16'd12 || odd_sum !== 16'd16 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL t1_totals got %0d/%0d/%0d/%0d/%0d exp 4/4/12/16/0",
                         even_cnt, odd_cnt, even_sum, odd_sum, err_cnt);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || even_cnt !== 8'd0 || odd_sum !== 16'd0) begin
      errors++; $display("FAIL t1_after out_valid=%b in_ready=%b even_cnt=%0d odd_sum=%0d exp 0/1/0/0",
                         out_valid, in_ready, even_cnt, odd_sum);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(frame1[i], ~frame1[i][0], frame1[i][0]);
    in_valid = 1'b1; num = 8'd9; even = 1'b0; odd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || even_cnt !== 8'd4 || odd_cnt !== 8'd4 ||
          even_sum !== 16'd12 || odd_sum !== 16'd16 || err_cnt !== 8'd0) begin
        errors++; $display("FAIL t2_hold_%0d ov=%b ir=%b got %0d/%0d/%0d/%0d/%0d exp 1/0 4/4/12/16/0", c,
                           out_valid, in_ready, even_cnt, odd_cnt, even_sum, odd_sum, err_cnt);
      end
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || odd_sum !== 16'd16) begin
      errors++; $display("FAIL t2_still_held out_valid=%b odd_sum=%0d exp 1/16", out_valid, odd_sum);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || odd_cnt !== 8'd0 || odd_sum !== 16'd0) begin
      errors++; $display("FAIL t2_cleared ov=%b ir=%b odd_cnt=%0d odd_sum=%0d exp 0/1/0/0",
                         out_valid, in_ready, odd_cnt, odd_sum);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (odd_cnt !== 8'd1 || odd_sum !== 16'd9 || even_cnt !== 8'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL t2_next_sample odd_cnt=%0d odd_sum=%0d even_cnt=%0d ov=%b exp 1/9/0/0",
                         odd_cnt, odd_sum, even_cnt, out_valid);
    end
  endtask

  task automatic test_error_flags();
    do_reset();
    for (int i = 0; i < 6; i++) send(8'd255, 1'b0, 1'b1);
    send(8'd4, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || err_cnt !== 8'd1 || even_sum !== 16'd0) begin
      errors++; $display("FAIL t3_mid ov=%b err_cnt=%0d even_sum=%0d exp 0/1/0", out_valid, err_cnt, even_sum);
    end
    send(8'd5, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || err_cnt !== 8'd2 || odd_cnt !== 8'd6 || odd_sum !== 16'd1530 ||
        even_cnt !== 8'd0 || even_sum !== 16'd0) begin
      errors++; $display("FAIL t3_totals ov=%b got err=%0d odd=%0d osum=%0d even=%0d esum=%0d exp 1 2/6/1530/0/0",
                         out_valid, err_cnt, odd_cnt, odd_sum, even_cnt, even_sum);
    end
    step();
  endtask

  task automatic test_gapped_input();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL t4_early_valid_%0d out_valid=%b exp 0", i, out_valid);
      end
      send(frame1[i], ~frame1[i][0], frame1[i][0]);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || even_cnt !== 8'd4 || odd_cnt !== 8'd4 || even_sum !== 16'd12 ||
        odd_sum !== 16'd16 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL t4_totals ov=%b got %0d/%0d/%0d/%0d/%0d exp 1 4/4/12/16/0",
                         out_valid, even_cnt, odd_cnt, even_sum, odd_sum, err_cnt);
    end
    step();
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    for (int i = 0; i < 5; i++) send(frame1[i], ~frame1[i][0], frame1[i][0]);
    rst = 1'b1; num = 8'd200; even = 1'b1; odd = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || {even_cnt, odd_cnt, err_cnt, even_sum, odd_sum} !== '0) begin
      errors++; $display("FAIL t5_reset ov=%b got %0d/%0d/%0d/%0d/%0d exp 0 all 0",
                         out_valid, even_cnt, odd_cnt, err_cnt, even_sum, odd_sum);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL t5_no_pulse_%0d out_valid=%b exp 0", i, out_valid);
      end
    end
    for (int i = 0; i < 7; i++) send(8'd2, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL t5_early out_valid=%b exp 0", out_valid);
    end
    send(8'd2, 1'b1, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || even_cnt !== 8'd8 || even_sum !== 16'd16 || odd_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL t5_totals ov=%b even_cnt=%0d even_sum=%0d odd=%0d err=%0d exp 1/8/16/0/0",
                         out_valid, even_cnt, even_sum, odd_cnt, err_cnt);
    end
    step();
  endtask

  task automatic test_large_sum();
    do_reset();
    for (int i = 0; i < 8; i++) send(8'd254, 1'b1, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || even_sum !== 16'd2032 || even_cnt !== 8'd8 || odd_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL t6_totals ov=%b even_sum=%0d even_cnt=%0d odd=%0d err=%0d exp 1/2032/8/0/0",
                         out_valid, even_sum, even_cnt, odd_cnt, err_cnt);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; num = '0; even = 1'b0; odd = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_error_flags();
    test_gapped_input();
    test_mid_frame_reset();
    test_large_sum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
